alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Sequencing stage directly upstream of the ALU. Accepts one instruction at a time over a valid/ready handshake. Fetches both source operands through the single synchronous-read register-file port, presents them to the combinational ALU, and writes the registered result back to the register file. Owns the execute-stage FSM. The ALU and register file stay purely datapath.

## Interface
Parameters:
- DATA_W, 32, operand/result width; must match the ALU.
- RA_W, 4, register address width (16 registers).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  block can accept; 1 only in IDLE with rst_n high.
- instr_op  in  3  ALU opcode: 0 add, 1 sub, 2 div, 3 mul, 4 mod, 5 less-than, 6 equal, 7 reserved (NOP).
- instr_rd  in  RA_W  destination register.
- instr_rs1  in  RA_W  source register for operand a.
- instr_rs2  in  RA_W  source register for operand b.
- rf_raddr  out  RA_W  register-file read address; rf_rdata is valid one cycle later.
- rf_rdata  in  DATA_W  register-file read data.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  RA_W  write address.
- rf_wdata  out  DATA_W  write data.
- alu_op  out  3  to ALU op.
- alu_a  out  DATA_W  to ALU a.
- alu_b  out  DATA_W  to ALU b.
- alu_res  in  DATA_W  from ALU res (combinational).
- done  out  1  one-cycle pulse on the instruction's final (WB) cycle.
- div_err  out  1  one-cycle pulse in WB when a divide-by-zero is trapped (see Configuration).

## Operation
- FSM states are IDLE, RD_A, RD_B, EXEC, WB.
- IDLE: instr_ready=1. On instr_valid && instr_ready, latch op, rd, rs1 and rs2, then go to RD_A. If instr_valid is low, stay in IDLE.
- RD_A: rf_raddr=rs1. Go to RD_B.
- RD_B: rf_raddr=rs2. Capture rf_rdata into a_q. Go to EXEC.
- EXEC: capture rf_rdata into b_q. Go to WB.
- WB:
  - Drive alu_a=a_q, alu_b=b_q and alu_op=op_q.
  - Drive rf_we=1, rf_waddr=rd_q and rf_wdata=alu_res.
  - Assert done=1, then go to IDLE.
- alu_a, alu_b and alu_op are driven from the latched registers in all states. They hold their values between instructions.
- rf_raddr is 0 in IDLE, EXEC and WB.
- Opcode 7: the full sequence runs, but rf_we stays 0 in WB. done still pulses.
- Arithmetic semantics, width and signedness belong to the ALU. This block passes alu_res through unmodified.
- No forwarding is needed. The WB write commits at the end of WB, and the next instruction's first read is issued in RD_A at the earliest 2 cycles later.
- rd may equal rs1 or rs2. Sources are read before the write.
- rd=0 is written like any other register.
- instr_* is ignored outside IDLE. The upstream stage must hold the instruction until the handshake completes.

## Timing
- Reset (rst_n low at an edge) puts the FSM in IDLE and clears a_q, b_q, op_q and rd_q to 0.
- Output values while rst_n is low and in the cycle after reset:
  - instr_ready=0 while rst_n is low, and 1 in the first cycle after rst_n goes high.
  - rf_we=0, done=0, div_err=0, rf_raddr=0.
  - alu_a=0, alu_b=0, alu_op=0, rf_waddr=0.
- Reset asserted mid-instruction aborts it. No write occurs, even if the FSM was in WB at the reset edge.
- Latency: accept at edge T. Then RD_A runs in cycle T+1, RD_B in T+2, EXEC in T+3, WB in T+4, and IDLE with ready=1 in T+5.
- Throughput is one instruction per 5 cycles.
- Back-to-back: if instr_valid is held high, the next accept occurs at the edge ending the first IDLE cycle after WB.

## Configuration
- Macro: ALU_DIVZERO_TRAP_EN.
- Defined: in WB, if op_q is 2 or 4 and b_q==0, then rf_we=0, div_err=1 and done=1. The ALU result is discarded.
- Not defined: div_err is tied to 0. Division and mod by zero write whatever alu_res presents.

## Test plan
- Add: r1=5, r2=7, op=0, rd=r3. Expect rf_we=1, rf_waddr=3 and rf_wdata=12 exactly 4 cycles after accept; done in the same cycle; instr_ready=1 one cycle later.
- Dependent back-to-back: sub r4=r3-r1 issued right after the add with valid held high. Expect r4=7 and accept exactly 5 cycles after the first accept.
- Opcode 7 with rd=r2. Expect no rf_we during the instruction, a done pulse at T+4, and r2 unchanged.
- Div r5=r1/r0 with r0=0:
  - Macro defined: div_err=1, rf_we=0, r5 unchanged.
  - Macro undefined: div_err=0, rf_we=1.
- Reset pulse in the EXEC cycle of a mul. Expect no write, all outputs at reset values, and instr_ready=1 in the first cycle after rst_n returns high.
- Equal, r6=(r1==r1), rd=r1 (destination equals both sources). Expect rf_wdata=1 to r1.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Execute-stage sequencer: reads two operands over the single RF read port,
// drives the ALU and writes back. Optional macro ALU_DIVZERO_TRAP_EN traps div/mod by zero.
module alu_issue_ctrl #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_op,
    input  logic [RA_W-1:0]   instr_rd,
    input  logic [RA_W-1:0]   instr_rs1,
    input  logic [RA_W-1:0]   instr_rs2,
    output logic [RA_W-1:0]   rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              rf_we,
    output logic [RA_W-1:0]   rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [2:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_res,
    output logic              done,
    output logic              div_err,
    output logic [2:0]        state_dbg
);

    // Handshake: an instruction transfers on a rising edge where instr_valid
    // and instr_ready are both high; the upstream holds instr_* stable until then.

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_EXEC = 3'd3,
        S_WB   = 3'd4
    } state_t;

    localparam logic [2:0] OP_NOP = 3'd7;
    localparam logic [2:0] OP_DIV = 3'd2;
    localparam logic [2:0] OP_MOD = 3'd4;

    state_t            state, state_nx;
    logic [2:0]        op_q;
    logic [RA_W-1:0]   rd_q, rs1_q, rs2_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic              div_trap;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            op_q  <= '0;
            rd_q  <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && instr_valid) begin
                op_q  <= instr_op;
                rd_q  <= instr_rd;
                rs1_q <= instr_rs1;
                rs2_q <= instr_rs2;
            end
            // Read data lags the address by one cycle, so each capture is one state late.
            if (state == S_RD_B) a_q <= rf_rdata;
            if (state == S_EXEC) b_q <= rf_rdata;
        end
    end

`ifdef ALU_DIVZERO_TRAP_EN
    assign div_trap = ((op_q == OP_DIV) || (op_q == OP_MOD)) && (b_q == '0);
`else
    assign div_trap = 1'b0;
`endif

    always_comb begin
        state_nx    = state;
        instr_ready = 1'b0;
        rf_raddr    = '0;
        rf_we       = 1'b0;
        done        = 1'b0;
        div_err     = 1'b0;
        case (state)
            S_IDLE: begin
                instr_ready = rst_n;
                if (instr_valid) state_nx = S_RD_A;
            end
            S_RD_A: begin
                rf_raddr = rst_n ? rs1_q : '0;
                state_nx = S_RD_B;
            end
            S_RD_B: begin
                rf_raddr = rst_n ? rs2_q : '0;
                state_nx = S_EXEC;
            end
            S_EXEC: state_nx = S_WB;
            S_WB: begin
                // Gating with rst_n aborts a write-back that coincides with reset.
                done     = rst_n;
                rf_we    = rst_n && (op_q != OP_NOP) && !div_trap;
                div_err  = rst_n && div_trap;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign alu_a     = rst_n ? a_q  : '0;
    assign alu_b     = rst_n ? b_q  : '0;
    assign alu_op    = rst_n ? op_q : '0;
    assign rf_waddr  = rst_n ? rd_q : '0;
    assign rf_wdata  = alu_res;
    assign state_dbg = state;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural RF and ALU around the DUT, transaction-level
// reference model feeding a scoreboard queue, directed cases plus random traffic.
module tb_alu_issue_ctrl;
  localparam int DATA_W = 32;
  localparam int RA_W   = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              instr_valid = 1'b0;
  logic              instr_ready;
  logic [2:0]        instr_op = '0;
  logic [RA_W-1:0]   instr_rd = '0, instr_rs1 = '0, instr_rs2 = '0;
  logic [RA_W-1:0]   rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              rf_we;
  logic [RA_W-1:0]   rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [2:0]        alu_op;
  logic [DATA_W-1:0] alu_a, alu_b, alu_res;
  logic              done, div_err;
  logic [2:0]        state_dbg;

  typedef struct {
    int              acc;
    logic [RA_W-1:0] rs1, rs2, rd;
    logic            we, derr;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] rf [16];
  logic [DATA_W-1:0] init_rf [16];
  logic [DATA_W-1:0] model_rf [16];
  logic              load = 1'b1;
  int                cyc = 0;
  int                errors = 0;
  int                checks = 0;
  int                last_acc = 0;
  bit                ready_pend = 0;

  alu_issue_ctrl #(.DATA_W(DATA_W), .RA_W(RA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res),
    .done(done), .div_err(div_err), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset / environment ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] ref_alu(input logic [2:0] op,
                                                input logic [DATA_W-1:0] a, b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return (b == 0) ? '1 : a / b;
      3'd3: return a * b;
      3'd4: return (b == 0) ? a : a % b;
      3'd5: return (a < b) ? 1 : 0;
      3'd6: return (a == b) ? 1 : 0;
      default: return '0;
    endcase
  endfunction

  always_comb alu_res = ref_alu(alu_op, alu_a, alu_b);

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 16; i++) rf[i] <= init_rf[i];
    end else if (rf_we) begin
      rf[rf_waddr] <= rf_wdata;
    end
    rf_rdata <= rf[rf_raddr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [2:0] op, input logic [RA_W-1:0] rd, rs1, rs2, input bit track);
    int n;
    exp_t e;
    logic [DATA_W-1:0] a, b;
    bit trap;
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
    n = 0;
    while (!instr_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!instr_ready) begin
      errors++;
      $display("FAIL accept_timeout: instr_ready stayed 0 for %0d cycles, required 1", n);
      instr_valid = 1'b0;
      return;
    end
    last_acc = cyc + 1;
    if (track) begin
      a = model_rf[rs1];
      b = model_rf[rs2];
      trap = 0;
`ifdef ALU_DIVZERO_TRAP_EN
      trap = (op == 3'd2 || op == 3'd4) && (b == 0);
`endif
      e.acc = last_acc; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
      e.we = (op != 3'd7) && !trap;
      e.derr = trap;
      e.data = ref_alu(op, a, b);
      if (e.we) model_rf[rd] = e.data;
      exp_q.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    instr_valid = 1'b0;
    instr_op = 3'($urandom); instr_rd = 4'($urandom);
    instr_rs1 = 4'($urandom); instr_rs2 = 4'($urandom);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d transactions outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"},   32'(instr_ready), 0);
    chk({tag, "_rf_we"},   32'(rf_we), 0);
    chk({tag, "_done"},    32'(done), 0);
    chk({tag, "_div_err"}, 32'(div_err), 0);
    chk({tag, "_raddr"},   32'(rf_raddr), 0);
    chk({tag, "_waddr"},   32'(rf_waddr), 0);
    chk({tag, "_alu_a"},   alu_a, 0);
    chk({tag, "_alu_b"},   alu_b, 0);
    chk({tag, "_alu_op"},  32'(alu_op), 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  // k counts negedges after the accept edge: 0 RD_A, 1 RD_B, 2 EXEC, 3 WB (T+4).
  int   mon_k;
  exp_t mon_e;
  always @(negedge clk) begin
    if (ready_pend) begin
      ready_pend = 0;
      if (rst_n) chk("ready_after_wb", 32'(instr_ready), 1);
    end
    if (exp_q.size() > 0) begin
      mon_e = exp_q[0];
      mon_k = cyc - mon_e.acc;
      if (mon_k >= 0 && mon_k <= 2) chk("no_early_done", 32'(done | rf_we | div_err), 0);
      if (mon_k == 0) chk("raddr_rs1", 32'(rf_raddr), 32'(mon_e.rs1));
      if (mon_k == 1) chk("raddr_rs2", 32'(rf_raddr), 32'(mon_e.rs2));
      if (mon_k == 2) chk("raddr_exec", 32'(rf_raddr), 0);
      if (mon_k == 3) begin
        chk("wb_done", 32'(done), 1);
        chk("wb_we", 32'(rf_we), 32'(mon_e.we));
        chk("wb_div_err", 32'(div_err), 32'(mon_e.derr));
        chk("wb_raddr", 32'(rf_raddr), 0);
        if (mon_e.we) begin
          chk("wb_waddr", 32'(rf_waddr), 32'(mon_e.rd));
          chk("wb_wdata", rf_wdata, mon_e.data);
        end
        void'(exp_q.pop_front());
        ready_pend = 1;
      end
    end else if (rst_n && !load) begin
      chk("no_stray_output", 32'(done | rf_we | div_err), 0);
    end
  end

  // ---------------- stimulus ----------------
  int first_acc;
  initial begin
    for (int i = 0; i < 16; i++) init_rf[i] = $urandom;
    init_rf[0] = 0; init_rf[1] = 5; init_rf[2] = 7; init_rf[5] = 32'h55;
    for (int i = 0; i < 16; i++) model_rf[i] = init_rf[i];

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    chk("reset_state", 32'(state_dbg), 0);
    load = 1'b0;
    rst_n = 1'b1;
    #1 chk("ready_after_reset", 32'(instr_ready), 1);

    // add r3=r1+r2, then dependent sub r4=r3-r1 with valid held high
    send(3'd0, 4'd3, 4'd1, 4'd2, 1'b1);
    first_acc = last_acc;
    send(3'd1, 4'd4, 4'd3, 4'd1, 1'b1);
    chk("b2b_accept_gap", 32'(last_acc - first_acc), 5);
    idle(0);
    drain();
    chk("add_r3", rf[3], 12);
    chk("sub_r4", rf[4], 7);

    // reserved opcode: full sequence, no write
    send(3'd7, 4'd2, 4'd1, 4'd1, 1'b1);
    idle(1);
    drain();
    chk("nop_r2", rf[2], 7);

    // divide by zero
    send(3'd2, 4'd5, 4'd1, 4'd0, 1'b1);
    idle(0);
    drain();
`ifdef ALU_DIVZERO_TRAP_EN
    chk("div0_r5", rf[5], 32'h55);
`else
    chk("div0_r5", rf[5], 32'hffff_ffff);
`endif

    // reset during EXEC of a mul aborts it
    send(3'd3, 4'd9, 4'd1, 4'd2, 1'b0);
    idle(0);                        // negedge k=0
    @(negedge clk);                 // k=1
    @(negedge clk);                 // k=2, EXEC
    rst_n = 1'b0;
    exp_q.delete();
    #1 chk_reset_outputs("midrst");
    @(negedge clk);
    chk_reset_outputs("midrst_idle");
    chk("midrst_state", 32'(state_dbg), 0);
    rst_n = 1'b1;
    #1 chk("midrst_ready", 32'(instr_ready), 1);
    chk("midrst_alu_a", alu_a, 0);
    repeat (3) @(negedge clk);
    chk("midrst_r9", rf[9], model_rf[9]);

    // equal with rd == rs1 == rs2
    send(3'd6, 4'd1, 4'd1, 4'd1, 1'b1);
    idle(0);
    drain();
    chk("eq_r1", rf[1], 1);

    // random traffic
    for (int i = 0; i < 150; i++) begin
      send(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 4'($urandom), 1'b1);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 3));
    end
    idle(0);
    drain();
    for (int i = 0; i < 16; i++) chk("final_rf", rf[i], model_rf[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
